instruction_cache: RTL and testbench

- Direct-mapped, read-only instruction cache; the initiator on the 128-bit block-read interface whose responder is the byte-serial instruction memory.
- Sits between the RISC-V fetch stage (32-bit PC, 32-bit instruction) and instruction memory.
- Hits return the instruction in the same cycle.
- Misses stall the CPU with `cpu_busywait`, issue one 28-bit block read, install the returned 16-byte line and then complete as a hit.

---
 rtl/instruction_cache_pkg.sv | 28 ++
 rtl/instruction_cache_if.sv | 35 +++
 rtl/instruction_cache_line_store.sv | 55 +++++
 rtl/instruction_cache.sv | 130 +++++++++++++
 tb/tb_instruction_cache.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_cache_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_pkg                                                       |
// | Shared types and constants for the direct-mapped instruction     |
// | cache: controller state encoding, line geometry and block        |
// | address helper.                                                  |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
package icache_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } icache_state_t;

  localparam int LINE_BYTES   = 16;
  localparam int OFFSET_W     = 4;
  localparam int BLOCK_ADDR_W = 28;
  localparam int LINE_W       = LINE_BYTES * 8;

  // Block address of a byte address: drops the 16-byte line offset.
  function automatic logic [BLOCK_ADDR_W-1:0] block_addr(input logic [31:0] byte_addr);
    return byte_addr[31:OFFSET_W];
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_cache_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_mem_if                                                    |
// | Block-read bus between the instruction cache (master) and the    |
// | instruction memory (slave).                                      |
// |   mem_read      master->slave  block-read request (level)        |
// |   mem_address   master->slave  28-bit block address              |
// |   mem_readdata  slave->master  128-bit line, byte i at [8i+7:8i] |
// |   mem_busywait  slave->master  busy; falls when data is valid    |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
interface icache_mem_if;
  import icache_pkg::*;

  logic                    mem_read;
  logic [BLOCK_ADDR_W-1:0] mem_address;
  logic [LINE_W-1:0]       mem_readdata;
  logic                    mem_busywait;

  modport master (
    output mem_read,
    output mem_address,
    input  mem_readdata,
    input  mem_busywait
  );

  modport slave (
    input  mem_read,
    input  mem_address,
    output mem_readdata,
    output mem_busywait
  );

endinterface
`default_nettype wire

// File: rtl/instruction_cache_line_store.sv
`default_nettype none
// +------------------------------------------------------------------+
// | icache_line_store                                                |
// | Valid/tag/data arrays for the direct-mapped cache.               |
// |   clock, reset   clock; asynchronous active-high valid clear     |
// |   rd_index       combinational read port index                   |
// |   rd_valid/tag/data  contents of the indexed line                |
// |   wr_en, wr_index, wr_tag, wr_data  single synchronous write     |
// | Tag and data arrays are intentionally not reset.                 |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8,
  parameter int IDX_W     = $clog2(NUM_LINES),
  parameter int TAG_W     = BLOCK_ADDR_W - IDX_W
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic [IDX_W-1:0]  rd_index,
  output logic                   rd_valid,
  output logic [TAG_W-1:0]       rd_tag,
  output logic [LINE_W-1:0]      rd_data,
  input  wire logic              wr_en,
  input  wire logic [IDX_W-1:0]  wr_index,
  input  wire logic [TAG_W-1:0]  wr_tag,
  input  wire logic [LINE_W-1:0] wr_data
);

  logic [NUM_LINES-1:0] r_valid;
  logic [TAG_W-1:0]     r_tag  [NUM_LINES];
  logic [LINE_W-1:0]    r_data [NUM_LINES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
    end else if (wr_en) begin
      r_valid[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      r_tag[wr_index]  <= wr_tag;
      r_data[wr_index] <= wr_data;
    end
  end

  assign rd_valid = r_valid[rd_index];
  assign rd_tag   = r_tag[rd_index];
  assign rd_data  = r_data[rd_index];

endmodule
`default_nettype wire

// File: rtl/instruction_cache.sv
`default_nettype none
// +------------------------------------------------------------------+
// | instruction_cache                                                |
// | Direct-mapped, read-only instruction cache between the fetch     |
// | stage and a block-read instruction memory. Hits complete in the  |
// | request cycle; misses stall, refill one 16-byte line, then hit.  |
// |   clock, reset      posedge clock; asynchronous active-high      |
// |   cpu_read          fetch request (level)                        |
// |   cpu_address       byte PC, bits [1:0] ignored                  |
// |   cpu_instruction   instruction of the addressed word            |
// |   cpu_busywait      stall to the fetch stage                     |
// |   mem               block-read bus (master side)                 |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module instruction_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 8
) (
  input  wire logic        clock,
  input  wire logic        reset,
  input  wire logic        cpu_read,
  input  wire logic [31:0] cpu_address,
  output logic [31:0]      cpu_instruction,
  output logic             cpu_busywait,
  icache_mem_if.master     mem
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = BLOCK_ADDR_W - IDX_W;

  icache_state_t           r_state;
  logic                    r_seen_busy;
  logic                    r_mem_read;
  logic [BLOCK_ADDR_W-1:0] r_mem_address;

  logic [1:0]        w_word;
  logic [IDX_W-1:0]  w_index;
  logic [TAG_W-1:0]  w_tag;
  logic              w_line_valid;
  logic [TAG_W-1:0]  w_line_tag;
  logic [LINE_W-1:0] w_line_data;
  logic              w_hit;
  logic              w_wr_en;
  logic              w_unused_addr_bits;

  assign w_word             = cpu_address[3:2];
  assign w_index            = cpu_address[OFFSET_W +: IDX_W];
  assign w_tag              = cpu_address[31 -: TAG_W];
  assign w_unused_addr_bits = ^cpu_address[1:0];

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W),
    .TAG_W     (TAG_W)
  ) u_line_store (
    .clock    (clock),
    .reset    (reset),
    .rd_index (w_index),
    .rd_valid (w_line_valid),
    .rd_tag   (w_line_tag),
    .rd_data  (w_line_data),
    .wr_en    (w_wr_en),
    .wr_index (w_index),
    .wr_tag   (w_tag),
    .wr_data  (mem.mem_readdata)
  );

  assign w_hit   = cpu_read & w_line_valid & (w_line_tag == w_tag);
  assign w_wr_en = (r_state == UPDATE);

  assign cpu_instruction = w_line_data[{w_word, 5'd0} +: 32];

  // Reset forces the stall low at once, even with cpu_read still high,
  // so an aborted refill never leaves the fetch stage stalled.
  always_comb begin
    cpu_busywait = 1'b1;
    case (r_state)
      IDLE:    cpu_busywait = cpu_read & ~w_hit;
      default: cpu_busywait = 1'b1;
    endcase
    if (reset) begin
      cpu_busywait = 1'b0;
    end
  end

  // The responder may take a cycle or more to raise busy after the
  // request, so a low busy only ends the transfer once busy was seen.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_seen_busy   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_address <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (cpu_read && !w_hit) begin
            r_state       <= MEM_READ;
            r_mem_read    <= 1'b1;
            r_mem_address <= block_addr(cpu_address);
          end
        end
        MEM_READ: begin
          if (mem.mem_busywait) begin
            r_seen_busy <= 1'b1;
          end
          if (r_seen_busy && !mem.mem_busywait) begin
            r_state    <= UPDATE;
            r_mem_read <= 1'b0;
          end
        end
        UPDATE: begin
          r_state     <= IDLE;
          r_seen_busy <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_seen_busy <= 1'b0;
          r_mem_read  <= 1'b0;
        end
      endcase
    end
  end

  assign mem.mem_read    = r_mem_read;
  assign mem.mem_address = r_mem_address;

endmodule
`default_nettype wire

// File: tb/tb_instruction_cache.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_instruction_cache                                             |
// | Directed self-checking bench for instruction_cache with a        |
// | behavioural block-read memory responder.                         |
// | Revision: 1.0 - initial release                                  |
// +------------------------------------------------------------------+
module tb_instruction_cache;

  logic        clock;
  logic        reset;
  logic        cpu_read;
  logic [31:0] cpu_address;
  logic [31:0] cpu_instruction;
  logic        cpu_busywait;

  icache_mem_if mif ();

  instruction_cache #(.NUM_LINES(8)) dut (
    .clock           (clock),
    .reset           (reset),
    .cpu_read        (cpu_read),
    .cpu_address     (cpu_address),
    .cpu_instruction (cpu_instruction),
    .cpu_busywait    (cpu_busywait),
    .mem             (mif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_vectors     = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vectors++;
    if (obs !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory image: block 0 holds fixed instructions, everything else a
  // recognisable function of its byte address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a[31:2])
      30'd0:   return 32'h3e800093;
      30'd1:   return 32'h00100113;
      30'd2:   return 32'h00208193;
      30'd3:   return 32'h0000f613;
      default: return {a[15:0] ^ 16'hc3a5, a[15:0]};
    endcase
  endfunction

  function automatic logic [127:0] mem_line(input logic [27:0] blk);
    logic [127:0] line;
    logic [1:0]   w;
    line = '0;
    for (int i = 0; i < 4; i++) begin
      w = i[1:0];
      line[32*i +: 32] = mem_word({blk, w, 2'b00});
    end
    return line;
  endfunction

  // Responder: pre_delay cycles of low busy after the request, then
  // lat cycles of busy, then data valid with busy low.
  int          pre_delay = 1;
  int          lat       = 3;
  int          n_reads   = 0;
  logic [27:0] read_addrs [$];

  initial begin
    logic [27:0] a;
    logic        aborted;
    mif.mem_busywait = 1'b0;
    mif.mem_readdata = '0;
    forever begin
      @(posedge clock); #1;
      if (mif.mem_read && !reset) begin
        a = mif.mem_address;
        n_reads++;
        read_addrs.push_back(a);
        repeat (pre_delay) begin @(posedge clock); #1; end
        mif.mem_busywait = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < lat; i++) begin
          @(posedge clock); #1;
          if (reset) begin
            aborted = 1'b1;
            break;
          end
        end
        if (!aborted) mif.mem_readdata = mem_line(a);
        mif.mem_busywait = 1'b0;
        for (int i = 0; i < 100 && mif.mem_read; i++) begin
          @(posedge clock); #1;
        end
      end
    end
  end

  // Fetch side must hold its address while stalled.
  logic        prev_busy = 1'b0;
  logic [31:0] prev_addr = '0;
  always @(negedge clock) begin
    if (!reset && cpu_read && prev_busy)
      assert (cpu_address == prev_addr) else $error("address changed during stall");
    prev_busy = cpu_busywait;
    prev_addr = cpu_address;
  end

  task automatic fetch(input logic [31:0] addr, output int stall, output logic mr0,
                       output logic mr1, output logic [27:0] ma1, output logic [31:0] instr);
    @(posedge clock); #1;
    cpu_address = addr;
    cpu_read    = 1'b1;
    stall = 0; mr0 = 1'b0; mr1 = 1'b0; ma1 = '0; instr = '0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (i == 0) mr0 = mif.mem_read;
      if (i == 1) begin
        mr1 = mif.mem_read;
        ma1 = mif.mem_address;
      end
      if (!cpu_busywait) begin
        instr = cpu_instruction;
        break;
      end
      stall++;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clock); #2;
    reset = 1'b1;
    cpu_read = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin
    int          stall;
    logic        mr0, mr1;
    logic [27:0] ma1;
    logic [31:0] instr;
    int          base;

    reset = 1'b1;
    cpu_read = 1'b0;
    cpu_address = '0;
    repeat (2) @(negedge clock);
    check("reset_busywait", {31'd0, cpu_busywait}, 32'd0);
    check("reset_mem_read", {31'd0, mif.mem_read}, 32'd0);
    check("reset_mem_addr", {4'd0, mif.mem_address}, 32'd0);
    @(posedge clock); #1 reset = 1'b0;

    // cpu_read low: no stall and no memory traffic
    cpu_address = 32'h200;
    repeat (3) @(negedge clock);
    check("idle_busywait", {31'd0, cpu_busywait}, 32'd0);
    check("idle_no_reads", n_reads, 0);

    // Cold miss at 0x00: 1 + (1 pre + 3 busy) + 1 update + 1 fill cycle
    fetch(32'h0, stall, mr0, mr1, ma1, instr);
    check("cold_mr_req_cycle", {31'd0, mr0}, 32'd0);
    check("cold_mr_next", {31'd0, mr1}, 32'd1);
    check("cold_maddr", {4'd0, ma1}, 32'd0);
    check("cold_stall", stall, 7);
    check("cold_instr", instr, 32'h3e800093);
    check("cold_mr_after", {31'd0, mif.mem_read}, 32'd0);

    // Hit in same line
    fetch(32'hC, stall, mr0, mr1, ma1, instr);
    check("hit_stall", stall, 0);
    check("hit_instr", instr, 32'h0000f613);
    check("hit_mem_read", {31'd0, mr0}, 32'd0);
    check("hit_reads", n_reads, 1);

    // Conflict: 0x80 shares index 0 with 0x00
    fetch(32'h80, stall, mr0, mr1, ma1, instr);
    check("conf_maddr", {4'd0, ma1}, 32'h8);
    check("conf_stall", stall, 7);
    check("conf_instr", instr, 32'hc3250080);
    fetch(32'h0, stall, mr0, mr1, ma1, instr);
    check("conf_reread_stall", stall, 7);
    check("conf_reread_instr", instr, 32'h3e800093);

    // Busy raised two cycles late: no premature update
    pre_delay = 3;
    fetch(32'h40, stall, mr0, mr1, ma1, instr);
    check("delay_stall", stall, 9);
    check("delay_instr", instr, 32'hc3e50040);
    pre_delay = 1;

    // Reset five cycles into a long busy window
    lat = 10;
    base = n_reads;
    @(posedge clock); #1;
    cpu_address = 32'h100;
    cpu_read = 1'b1;
    for (int i = 0; i < 20 && !mif.mem_busywait; i++) begin
      @(posedge clock); #1;
    end
    repeat (5) @(posedge clock);
    #2;
    check("rst_mid_busy_before", {31'd0, mif.mem_busywait}, 32'd1);
    reset = 1'b1;
    cpu_read = 1'b0;
    #1;
    check("rst_mid_mem_read", {31'd0, mif.mem_read}, 32'd0);
    check("rst_mid_busywait", {31'd0, cpu_busywait}, 32'd0);
    check("rst_mid_reads", n_reads - base, 1);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    lat = 3;
    fetch(32'h0, stall, mr0, mr1, ma1, instr);
    check("rst_remiss_stall", stall, 7);
    check("rst_remiss_instr", instr, 32'h3e800093);

    // Sequential sweep of four lines from a cold cache
    pulse_reset();
    base = n_reads;
    for (int k = 0; k < 16; k++) begin
      logic [31:0] a;
      a = 32'(k) * 32'd4;
      fetch(a, stall, mr0, mr1, ma1, instr);
      check($sformatf("sweep_%02h", a), instr, mem_word(a));
    end
    check("sweep_reads", n_reads - base, 4);
    for (int k = 0; k < 4; k++) begin
      if (base + k < read_addrs.size())
        check($sformatf("sweep_addr%0d", k), {4'd0, read_addrs[base+k]}, 32'(k));
      else
        check($sformatf("sweep_addr%0d_missing", k), 32'd0, 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
